// File: rtl/ccff_loader_pkg.sv
// Shared types and defaults for the configuration-chain loader.
// The FSM encoding and the default chain geometry live here so the sub-blocks agree.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ccff_ld_state_t;

    localparam int CCFF_DATA_W    = 8;
    localparam int CCFF_CHAIN_LEN = 16;

    // Width of an index into an n-bit word; a 1-bit word still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// One-word buffer that turns a host word into a bit stream, LSB first.
// A new word may load in the same cycle the previous word's last bit is consumed.
module ccff_word_serializer
    import ccff_loader_pkg::*;
#(
    parameter int DATA_W = CCFF_DATA_W,
    parameter int IDX_W  = idx_width(DATA_W),
    parameter int HELD_W = $clog2(DATA_W + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              consume,
    output logic              word_valid,
    output logic              bit_out,
    output logic              last_bit,
    output logic [HELD_W-1:0] bits_held
);

    logic [DATA_W-1:0] word_q;
    logic [IDX_W-1:0]  bit_idx;

    assign bit_out   = word_q[bit_idx];
    assign last_bit  = word_valid && (bit_idx == IDX_W'(DATA_W - 1));
    assign bits_held = word_valid ? (HELD_W'(DATA_W) - HELD_W'(bit_idx)) : '0;

    // Load wins over consume: when both happen the old word is on its last bit.
    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            word_q     <= '0;
            word_valid <= 1'b0;
            bit_idx    <= '0;
        end else if (clear) begin
            word_q     <= '0;
            word_valid <= 1'b0;
            bit_idx    <= '0;
        end else if (load) begin
            word_q     <= load_data;
            word_valid <= 1'b1;
            bit_idx    <= '0;
        end else if (consume) begin
            if (last_bit) begin
                word_valid <= 1'b0;
                bit_idx    <= '0;
            end else begin
                bit_idx <= bit_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serial loader for a routing tile's CCFF chain: emits exactly CHAIN_LEN bits on ccff_head
// with a per-bit shift enable, and folds the bits leaving ccff_tail into a parity.
//
//   state | meaning
//   IDLE  | out of reset, waiting for start
//   LOAD  | shifting host words into the chain
//   DONE  | CHAIN_LEN bits shifted, parity final, waiting for start
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int DATA_W    = CCFF_DATA_W,
    parameter int CHAIN_LEN = CCFF_CHAIN_LEN,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              tail_parity
);

    localparam int HELD_W = $clog2(DATA_W + 1);

    ccff_ld_state_t    state;
    ccff_ld_state_t    state_nxt;
    logic [CNT_W-1:0]  remaining;
    logic              start_take;
    logic              shift;
    logic              final_shift;
    logic              accept;
    logic              room;
    logic              word_valid;
    logic              word_bit;
    logic              word_last;
    logic [HELD_W-1:0] bits_held;

    assign start_take  = start && (state != LOAD);
    assign shift       = (state == LOAD) && word_valid && (remaining != '0);
    assign final_shift = shift && (remaining == CNT_W'(1));
    assign accept      = in_valid && in_ready;
    // Only take a word if the chain still has room beyond what is already buffered.
    assign room        = 32'(remaining) > 32'(bits_held);

    ccff_word_serializer #(
        .DATA_W (DATA_W)
    ) u_serializer (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .clear      (start_take || final_shift),
        .load       (accept),
        .load_data  (in_data),
        .consume    (shift),
        .word_valid (word_valid),
        .bit_out    (word_bit),
        .last_bit   (word_last),
        .bits_held  (bits_held)
    );

    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_take) state_nxt = LOAD;
            LOAD:    if (final_shift) state_nxt = DONE;
            DONE:    if (start_take) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        ccff_shift_en = 1'b0;
        ccff_head     = 1'b0;
        in_ready      = 1'b0;
        case (state)
            LOAD: begin
                busy          = 1'b1;
                ccff_shift_en = shift;
                ccff_head     = shift && word_bit;
                in_ready      = room && (!word_valid || (shift && word_last));
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            remaining   <= '0;
            tail_parity <= 1'b0;
        end else if (start_take) begin
            remaining   <= CNT_W'(CHAIN_LEN);
            tail_parity <= 1'b0;
        end else if (shift) begin
            remaining   <= remaining - CNT_W'(1);
            tail_parity <= tail_parity ^ ccff_tail;
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: a 16-bit chain instance with a bit scoreboard
// and a 12-bit chain instance for truncation, each driving a behavioural CCFF chain.
module tb_ccff_chain_loader;
    import ccff_loader_pkg::*;

    logic prog_clk   = 1'b0;
    logic prog_reset = 1'b0;
    always #5 prog_clk = ~prog_clk;

    int checks = 0;
    int errors = 0;

    // 16-bit chain instance
    logic       a_start = 1'b0;
    logic       a_valid = 1'b0;
    logic [7:0] a_data  = '0;
    logic       a_ready, a_head, a_shift, a_tail, a_busy, a_done, a_par;

    // 12-bit chain instance
    logic       b_start = 1'b0;
    logic       b_valid = 1'b0;
    logic [7:0] b_data  = '0;
    logic       b_ready, b_head, b_shift, b_tail, b_busy, b_done, b_par;

    ccff_chain_loader #(.DATA_W(8), .CHAIN_LEN(16)) dut_a (
        .prog_clk      (prog_clk),
        .prog_reset    (prog_reset),
        .start         (a_start),
        .in_data       (a_data),
        .in_valid      (a_valid),
        .in_ready      (a_ready),
        .ccff_head     (a_head),
        .ccff_shift_en (a_shift),
        .ccff_tail     (a_tail),
        .busy          (a_busy),
        .done          (a_done),
        .tail_parity   (a_par)
    );

    ccff_chain_loader #(.DATA_W(8), .CHAIN_LEN(12)) dut_b (
        .prog_clk      (prog_clk),
        .prog_reset    (prog_reset),
        .start         (b_start),
        .in_data       (b_data),
        .in_valid      (b_valid),
        .in_ready      (b_ready),
        .ccff_head     (b_head),
        .ccff_shift_en (b_shift),
        .ccff_tail     (b_tail),
        .busy          (b_busy),
        .done          (b_done),
        .tail_parity   (b_par)
    );

    // Behavioural chains: head enters at the top, tail leaves from bit 0.
    logic [15:0] a_chain   = '0;
    logic [15:0] a_pre_val = '0;
    logic        a_pre     = 1'b0;
    logic [11:0] b_chain   = '0;
    logic [11:0] b_pre_val = '0;
    logic        b_pre     = 1'b0;

    always @(posedge prog_clk) begin
        if (a_pre) a_chain <= a_pre_val;
        else if (a_shift) a_chain <= {a_head, a_chain[15:1]};
        if (b_pre) b_chain <= b_pre_val;
        else if (b_shift) b_chain <= {b_head, b_chain[11:1]};
    end
    assign a_tail = a_chain[0];
    assign b_tail = b_chain[0];

    logic exp_q[$];
    int   a_rem        = 0;
    int   a_shifts     = 0;
    int   a_gap        = 0;
    int   a_last_shift = 0;
    int   a_done_rise  = 0;
    logic a_done_d     = 1'b0;
    int   b_shifts     = 0;
    int   b_accepts    = 0;
    int   cyc          = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge prog_clk) begin
        logic e;
        cyc++;
        if (a_shift) begin
            chk("a_unexpected_shift", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("a_head_bit", 32'(a_head), 32'(e));
            end
            a_shifts++;
            a_last_shift = cyc;
        end else if (a_busy && a_shifts > 0) begin
            a_gap++;
        end
        if (a_done && !a_done_d) a_done_rise = cyc;
        a_done_d = a_done;
        if (b_shift) b_shifts++;
        if (b_valid && b_ready) b_accepts++;
    end

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic preload_a(input logic [15:0] v);
        a_pre_val = v;
        a_pre     = 1'b1;
        tick();
        a_pre     = 1'b0;
    endtask

    task automatic preload_b(input logic [11:0] v);
        b_pre_val = v;
        b_pre     = 1'b1;
        tick();
        b_pre     = 1'b0;
    endtask

    task automatic start_a();
        a_rem    = 16;
        exp_q.delete();
        a_shifts = 0;
        a_gap    = 0;
        a_start  = 1'b1;
        tick();
        a_start  = 1'b0;
    endtask

    task automatic start_b();
        b_shifts  = 0;
        b_accepts = 0;
        b_start   = 1'b1;
        tick();
        b_start   = 1'b0;
    endtask

    task automatic send_a(input logic [7:0] w);
        int n = 0;
        a_data  = w;
        a_valid = 1'b1;
        while (!a_ready && n < 100) begin
            tick();
            n++;
        end
        chk("a_accept_in_time", 32'(n < 100), 1);
        for (int i = 0; i < 8; i++) begin
            if (a_rem > 0) begin
                exp_q.push_back(w[i]);
                a_rem--;
            end
        end
        tick();
        a_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] w);
        int n = 0;
        b_data  = w;
        b_valid = 1'b1;
        while (!b_ready && n < 100) begin
            tick();
            n++;
        end
        chk("b_accept_in_time", 32'(n < 100), 1);
        tick();
        b_valid = 1'b0;
    endtask

    task automatic wait_done_a();
        int n = 0;
        while (!a_done && n < 200) begin
            tick();
            n++;
        end
        chk("a_done_in_time", 32'(a_done), 1);
        @(negedge prog_clk);
        #1;
    endtask

    task automatic wait_done_b();
        int n = 0;
        while (!b_done && n < 200) begin
            tick();
            n++;
        end
        chk("b_done_in_time", 32'(b_done), 1);
    endtask

    initial begin
        int n;
        #1;
        chk("a_reset_outs", 32'({a_ready, a_head, a_shift, a_busy, a_done, a_par}), 0);
        chk("b_reset_outs", 32'({b_ready, b_head, b_shift, b_busy, b_done, b_par}), 0);
        repeat (2) tick();
        prog_reset = 1'b1;
        tick();

        // Basic back-to-back load with odd-parity preload
        preload_a(16'h0007);
        start_a();
        chk("a_busy_after_start", 32'(a_busy), 1);
        send_a(8'hA5);
        chk("a_first_shift_next_cycle", 32'(a_shift), 1);
        send_a(8'h3C);
        wait_done_a();
        chk("a_basic_shifts", 32'(a_shifts), 16);
        chk("a_basic_gap", 32'(a_gap), 0);
        chk("a_basic_done_latency", 32'(a_done_rise - a_last_shift), 1);
        chk("a_basic_chain", 32'(a_chain), 32'h3CA5);
        chk("a_basic_parity", 32'(a_par), 1);
        chk("a_basic_shift_off_in_done", 32'({a_shift, a_busy}), 0);
        chk("a_basic_queue_drained", 32'(exp_q.size()), 0);

        // Restart from DONE with a 3-cycle host stall and even-parity preload
        preload_a(16'h0003);
        start_a();
        chk("a_done_cleared_on_start", 32'(a_done), 0);
        chk("a_busy_on_restart", 32'(a_busy), 1);
        send_a(8'hA5);
        repeat (10) tick();
        send_a(8'h3C);
        wait_done_a();
        chk("a_stall_shifts", 32'(a_shifts), 16);
        chk("a_stall_gap", 32'(a_gap), 3);
        chk("a_stall_chain", 32'(a_chain), 32'h3CA5);
        chk("a_stall_parity", 32'(a_par), 0);

        // start while loading is ignored
        preload_a(16'h0000);
        start_a();
        send_a(8'h5A);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("a_busy_after_ignored_start", 32'(a_busy), 1);
        send_a(8'hC3);
        wait_done_a();
        chk("a_ignored_start_shifts", 32'(a_shifts), 16);
        chk("a_ignored_start_chain", 32'(a_chain), 32'hC35A);
        chk("a_ignored_start_queue", 32'(exp_q.size()), 0);

        // Asynchronous reset after the 5th shift, then a full reload
        preload_a(16'hFFFF);
        start_a();
        send_a(8'h3C);
        n = 0;
        while (a_shifts < 5 && n < 60) begin
            tick();
            n++;
        end
        chk("a_reached_5_shifts", 32'(a_shifts), 5);
        chk("a_mid_parity", 32'(a_par), 1);
        chk("a_mid_shift_en", 32'(a_shift), 1);
        prog_reset = 1'b0;
        #1;
        chk("a_async_reset_outs", 32'({a_ready, a_head, a_shift, a_busy, a_done, a_par}), 0);
        exp_q.delete();
        tick();
        prog_reset = 1'b1;
        tick();
        chk("a_idle_after_reset", 32'({a_busy, a_done}), 0);
        preload_a(16'h0000);
        start_a();
        send_a(8'h96);
        send_a(8'h69);
        wait_done_a();
        chk("a_reload_shifts", 32'(a_shifts), 16);
        chk("a_reload_chain", 32'(a_chain), 32'h6996);
        chk("a_reload_done_latency", 32'(a_done_rise - a_last_shift), 1);

        // Truncation on the 12-bit chain
        preload_b(12'h000);
        start_b();
        send_b(8'hFF);
        send_b(8'h0F);
        b_data  = 8'hAA;
        b_valid = 1'b1;
        wait_done_b();
        repeat (3) tick();
        chk("b_ready_low_after_trunc", 32'(b_ready), 0);
        b_valid = 1'b0;
        chk("b_trunc_shifts", 32'(b_shifts), 12);
        chk("b_trunc_chain", 32'(b_chain), 32'hFFF);
        chk("b_trunc_accepts", 32'(b_accepts), 2);
        chk("b_trunc_done_held", 32'(b_done), 1);
        chk("b_trunc_parity", 32'(b_par), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
